// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared constants, state encoding and frame packing helper for
//            the register-interface SPI initiator.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Register map shared with the peripheral
    localparam logic [ADDR_W-1:0] EN_OUT_LO = 7'd0;
    localparam logic [ADDR_W-1:0] EN_OUT_HI = 7'd1;
    localparam logic [ADDR_W-1:0] EN_PWM_LO = 7'd2;
    localparam logic [ADDR_W-1:0] EN_PWM_HI = 7'd3;
    localparam logic [ADDR_W-1:0] DUTY      = 7'd4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SCLK_HI = 3'd2,
        SCLK_LO = 3'd3,
        HOLD    = 3'd4,
        GAP     = 3'd5
    } spi_state_e;

    // Frame layout on the wire, MSB first: {rw, addr, data}
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {rw, addr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_half_period_timer.sv
`default_nettype none
// ============================================================================
// Module   : spi_half_period_timer
// Purpose  : Load/expire down-counter. A load of N makes expire_o assert on
//            the N-th cycle after the load edge, so a state that loads on
//            entry and leaves on expire lasts exactly N cycles.
// Ports    : clk, rst_n      - clock, async active-low reset
//            load_i          - reload the counter this edge
//            load_val_i      - phase length in cycles (>= 1)
//            expire_o        - counter has reached zero
// Revision : 1.0 - initial release
// ============================================================================
module spi_half_period_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i - WIDTH'(1);
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module   : spi_controller
// Purpose  : SPI mode-0 initiator for the chip register interface. Sends one
//            16-bit frame {rw, addr[6:0], data[7:0]} per accepted request and
//            captures the read byte from CIPO on SCLK rises 9..16.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            req_valid/req_ready        - request handshake
//            req_rw, req_addr, req_data - request fields
//            spi_ncs, spi_sclk, spi_copi, spi_cipo - serial bus
//            rd_data                    - last read result
//            busy, done                 - frame in progress / end pulse
// Revision : 1.0 - initial release
// ============================================================================
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              spi_ncs,
    output logic              spi_sclk,
    output logic              spi_copi,
    input  logic              spi_cipo,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);

    localparam int TMR_W = 16;

    spi_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [3:0]             bit_q, bit_d;
    logic                   rw_q, rw_d;
    logic [DATA_W-1:0]      shadow_q, shadow_d;
    logic [DATA_W-1:0]      rd_q, rd_d;
    logic                   ncs_q, ncs_d;
    logic                   sclk_q, sclk_d;
    logic                   copi_q, copi_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   w_accept;
    logic                   w_expire;
    logic                   w_load;
    logic [TMR_W-1:0]       w_load_val;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_end;

    // ready_q is only ever high in IDLE, so it doubles as the state qualifier
    assign w_accept = req_valid && ready_q;

    // Every state change starts a new timed phase
    assign w_load     = (state_d != state_q);
    assign w_load_val = (state_d == GAP) ? TMR_W'(GAP_CYCLES) : TMR_W'(CLK_DIV);

    assign w_rise = (state_d == SCLK_HI) && (state_q != SCLK_HI);
    assign w_fall = (state_d == SCLK_LO) && (state_q == SCLK_HI);
    assign w_end  = (state_d == GAP) && (state_q == HOLD);

    spi_half_period_timer #(
        .WIDTH      (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .expire_o   (w_expire)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; bit_q counts completed low phases
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = SETUP;
                    bit_d   = 4'd0;
                end
            end
            SETUP: begin
                if (w_expire) state_d = SCLK_HI;
            end
            SCLK_HI: begin
                if (w_expire) state_d = SCLK_LO;
            end
            SCLK_LO: begin
                if (w_expire) begin
                    if (bit_q == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SCLK_HI;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (w_expire) state_d = GAP;
            end
            GAP: begin
                if (w_expire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: frame shifter, read shadow, read result
    // ------------------------------------------------------------------
    always_comb begin
        shift_d  = shift_q;
        rw_d     = rw_q;
        shadow_d = shadow_q;
        rd_d     = rd_q;
        if (w_accept) begin
            shift_d = pack_frame(req_rw, req_addr, req_data);
            rw_d    = req_rw;
        end else if (w_fall) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end
        // bit_d equals (rise number - 1) on a rising edge, so bit 3 marks rises 9..16
        if (w_rise && bit_d[3]) begin
            shadow_d = {shadow_q[DATA_W-2:0], spi_cipo};
        end
        if (w_end && (rw_q == RW_READ)) begin
            rd_d = shadow_q;
        end
    end

    // ------------------------------------------------------------------
    // Output logic, computed from the upcoming state so every pin is a flop
    // ------------------------------------------------------------------
    always_comb begin
        ncs_d   = !((state_d == SETUP) || (state_d == SCLK_HI) ||
                    (state_d == SCLK_LO) || (state_d == HOLD));
        sclk_d  = (state_d == SCLK_HI);
        // shift_d only moves on a falling SCLK, keeping COPI stable while high
        copi_d  = shift_d[FRAME_BITS-1] && !ncs_d;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = w_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bit_q    <= '0;
            rw_q     <= 1'b0;
            shadow_q <= '0;
            rd_q     <= '0;
            ncs_q    <= 1'b1;
            sclk_q   <= 1'b0;
            copi_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            rw_q     <= rw_d;
            shadow_q <= shadow_d;
            rd_q     <= rd_d;
            ncs_q    <= ncs_d;
            sclk_q   <= sclk_d;
            copi_q   <= copi_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = ready_q;
    assign spi_ncs   = ncs_q;
    assign spi_sclk  = sclk_q;
    assign spi_copi  = copi_q;
    assign rd_data   = rd_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_controller
// Purpose  : Randomised scoreboard bench for spi_controller with a CIPO
//            responder and a bus-level protocol monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 4;
    localparam int NCS_LOW    = 34 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       spi_cipo = 1'b0;
    logic       req_ready;
    logic       spi_ncs;
    logic       spi_sclk;
    logic       spi_copi;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    spi_controller #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .spi_ncs    (spi_ncs),
        .spi_sclk   (spi_sclk),
        .spi_copi   (spi_copi),
        .spi_cipo   (spi_cipo),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] frame;
        logic        rw;
        logic [7:0]  cipo;
        logic [31:0] acc_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cipo_q[$];
    logic [7:0] model_rd = '0;
    int         rise_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lo);
        checks++;
        if (act < lo) begin
            failures++;
            $display("FAIL %s actual=%0d required>=%0d (t=%0t)", name, act, lo, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send(input logic rw, input logic [6:0] addr,
                        input logic [7:0] data, input logic [7:0] cb);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_data  = data;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", int'(req_ready), 1);
            req_valid = 1'b0;
            return;
        end
        e.frame   = 16'((rw ? 32768 : 0) + int'(addr) * 256 + int'(data));
        e.rw      = rw;
        e.cipo    = cb;
        e.acc_cyc = 32'(cyc + 1);
        exp_q.push_back(e);
        cipo_q.push_back(cb);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        req_rw    = 1'($urandom);
        req_addr  = 7'($urandom);
        req_data  = 8'($urandom);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending_frames", exp_q.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // CIPO responder: garbage before rise 9, then the queued byte MSB first,
    // changing only while SCLK is high
    // ------------------------------------------------------------------
    initial begin : cipo_model
        logic [7:0] cur = '0;
        int         s_cnt = 0;
        logic       s_prev_ncs = 1'b1;
        logic       s_prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cipo_q.delete();
                s_cnt       = 0;
                s_prev_ncs  = 1'b1;
                s_prev_sclk = 1'b0;
                spi_cipo    = 1'b0;
                continue;
            end
            if (s_prev_ncs && !spi_ncs) begin
                cur   = (cipo_q.size() > 0) ? cipo_q.pop_front() : 8'h00;
                s_cnt = 0;
            end
            if (!spi_ncs && !s_prev_sclk && spi_sclk) s_cnt++;
            if (s_cnt >= 8 && s_cnt < 16) spi_cipo = cur[15 - s_cnt];
            else                          spi_cipo = 1'($urandom);
            s_prev_ncs  = spi_ncs;
            s_prev_sclk = spi_sclk;
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
        logic [7:0]  prev_rd = '0;
        logic [15:0] captured = '0;
        int          low_cnt = 0, hi_cnt = 0, fall_cyc = 0, last_rise_cyc = 0;
        int          ncs_rise_cyc = 0;
        bit          have_rise = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_rd  = '0;
                rise_cnt  = 0;
                prev_ncs  = 1'b1;
                prev_sclk = 1'b0;
                prev_copi = 1'b0;
                prev_rd   = '0;
                have_rise = 1'b0;
                continue;
            end
            if (prev_ncs && !spi_ncs) begin
                low_cnt  = 0;
                rise_cnt = 0;
                captured = '0;
                fall_cyc = cyc;
                chk("frame_expected_at_ncs_fall", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("ncs_fall_latency", cyc, int'(exp_q[0].acc_cyc));
                if (have_rise) chk_ge("ncs_gap", cyc - ncs_rise_cyc, GAP_CYCLES);
                chk("rd_data_held", int'(rd_data), int'(model_rd));
            end
            if (!spi_ncs) begin
                low_cnt++;
                chk("req_ready_low_in_frame", int'(req_ready), 0);
                chk("busy_in_frame", int'(busy), 1);
            end
            if (!prev_sclk && spi_sclk) begin
                chk("rise_with_ncs_low", int'(spi_ncs), 0);
                rise_cnt++;
                captured = {captured[14:0], spi_copi};
                if (rise_cnt == 1) chk("first_rise_latency", cyc - fall_cyc, CLK_DIV);
                else               chk("sclk_period", cyc - last_rise_cyc, 2 * CLK_DIV);
                last_rise_cyc = cyc;
                hi_cnt = 0;
            end
            if (spi_sclk) begin
                hi_cnt++;
                chk("copi_stable_while_sclk_high", int'(spi_copi), int'(prev_copi));
            end
            if (prev_sclk && !spi_sclk) chk("sclk_high_width", hi_cnt, CLK_DIV);
            if (done) chk("done_only_at_ncs_rise", int'(!prev_ncs && spi_ncs), 1);
            if (rd_data != prev_rd) chk("rd_data_changes_only_on_done", int'(done), 1);
            if (!prev_ncs && spi_ncs) begin
                ncs_rise_cyc = cyc;
                have_rise    = 1'b1;
                chk("ncs_low_cycles", low_cnt, NCS_LOW);
                chk("sclk_rise_count", rise_cnt, 16);
                chk("done_at_frame_end", int'(done), 1);
                chk("frame_expected_at_end", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("copi_frame_bits", int'(captured), int'(e.frame));
                    if (!e.rw) model_rd = e.cipo;
                    chk("rd_data_on_done", int'(rd_data), int'(model_rd));
                end
            end
            prev_ncs  = spi_ncs;
            prev_sclk = spi_sclk;
            prev_copi = spi_copi;
            prev_rd   = rd_data;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        int n;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ncs", int'(spi_ncs), 1);
        chk("reset_sclk", int'(spi_sclk), 0);
        chk("reset_copi", int'(spi_copi), 0);
        chk("reset_req_ready", int'(req_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(req_ready), 1);

        // Directed: write, read, back-to-back writes with valid held high
        send(1'b1, 7'h00, 8'hF0, 8'h3C);
        idle(10);
        send(1'b0, 7'h04, 8'($urandom), 8'hA5);
        idle(10);
        send(1'b1, 7'h04, 8'h80, 8'h00);
        send(1'b1, 7'h02, 8'h0F, 8'h00);
        idle(3);
        drain();

        // Randomised traffic, mixing held-valid and idle gaps
        for (int i = 0; i < 20; i++) begin
            send(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
        end
        idle(1);
        drain();

        // Reset during the 7th SCLK high phase
        send(1'b0, 7'($urandom), 8'($urandom), 8'($urandom));
        idle(1);
        n = 0;
        while (rise_cnt < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_rise_7", int'(rise_cnt >= 7), 1);
        @(posedge clk);
        #2;
        chk("sclk_high_before_reset", int'(spi_sclk), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_ncs", int'(spi_ncs), 1);
        chk("async_reset_sclk", int'(spi_sclk), 0);
        chk("async_reset_copi", int'(spi_copi), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midframe_reset", int'(req_ready), 1);
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("no_done_after_abort", n, 0);
        chk("rd_data_after_abort", int'(rd_data), 0);

        // Recovery: a fresh read after the aborted frame
        send(1'b0, 7'h01, 8'h00, 8'($urandom));
        idle(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
